// File: rtl/rom_stream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rom_stream_loader: parses headed ioctl regions into SDRAM words / BRAM     |
// | bytes. Optional checksum: LOADER_CHECKSUM_EN.  Revision: 1.0               |
// +----------------------------------------------------------------------------+
module rom_stream_loader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 25,
  parameter int NUM_BRAM   = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int SDR_BASE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [7:0]            ioctl_data,
  output logic                  ioctl_wait,
  output logic [ADDR_W-1:0]     sdr_addr,
  output logic [DATA_W-1:0]     sdr_data,
  output logic [DATA_W/8-1:0]   sdr_be,
  output logic                  sdr_req,
  input  logic                  sdr_rdy,
  output logic [19:0]           bram_addr,
  output logic [7:0]            bram_data,
  output logic [NUM_BRAM-1:0]   bram_cs,
  output logic                  bram_wr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           checksum
);
  localparam int c_bytes = DATA_W / 8;
  localparam int c_lw    = $clog2(c_bytes);
  localparam int c_pw    = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(SDR_BASE);
  localparam logic [c_pw:0]     c_thr  = (c_pw+1)'(FIFO_DEPTH - 1);
  localparam logic [c_pw:0]     c_full = (c_pw+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HDR = 3'd1, S_DATA = 3'd2, S_PAD = 3'd3,
    S_DRAIN = 3'd4, S_DONE = 3'd5, S_DONE_ERR = 3'd6
  } state_t;

  state_t              r_state;
  logic                r_dl_q, r_wait_q, r_err, r_busy, r_done, r_to_sdr;
  logic [1:0]          r_hcnt;
  logic [7:0]          r_dest;
  logic [23:0]         r_len;
  logic [c_lw-1:0]     r_lane;
  logic [DATA_W-1:0]   r_word;
  logic [ADDR_W-1:0]   r_wptr;
  logic [19:0]         r_bofs, r_baddr;
  logic [7:0]          r_bdata;
  logic [NUM_BRAM-1:0] r_bcs;
  logic                r_bwr;

  logic [ADDR_W-1:0]   r_fa [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fd [FIFO_DEPTH];
  logic [c_bytes-1:0]  r_fb [FIFO_DEPTH];
  logic [c_pw-1:0]     r_wp, r_rp;
  logic [c_pw:0]       r_cnt;
  logic                r_req;

  logic                w_rise, w_fall, w_active, w_acc, w_drop, w_pop, w_push;
  logic                w_lane_last, w_full;
  logic [23:0]         w_len_full;
  logic [DATA_W-1:0]   w_word_ins, w_push_data;
  logic [c_bytes-1:0]  w_pad_be, w_push_be;
  logic [NUM_BRAM-1:0] w_bcs_sel;

  assign w_rise      = ioctl_download & ~r_dl_q;
  assign w_fall      = ~ioctl_download & r_dl_q;
  assign w_active    = (r_state == S_HDR) || (r_state == S_DATA) ||
                       (r_state == S_PAD) || (r_state == S_DRAIN);
  // Acceptance looks at last cycle's wait so a host reacting one cycle late still fits the FIFO.
  assign w_acc       = ioctl_wr & ~r_wait_q & w_active;
  assign w_drop      = ioctl_wr &  r_wait_q & w_active;
  assign w_pop       = r_req & sdr_rdy;
  assign w_full      = (r_cnt == c_full);
  assign w_lane_last = (r_lane == c_lw'(c_bytes - 1));
  assign w_len_full  = {r_len[15:0], ioctl_data};
  assign ioctl_wait  = (r_cnt >= c_thr) || (r_state == S_PAD) || (r_state == S_DRAIN);

  always_comb begin
    w_word_ins = r_word;
    w_pad_be   = '0;
    for (int i = 0; i < c_bytes; i++) begin
      if (r_lane == c_lw'(i)) w_word_ins[8*i +: 8] = ioctl_data;
      if (c_lw'(i) < r_lane)  w_pad_be[i] = 1'b1;
    end
    w_bcs_sel = '0;
    for (int i = 0; i < NUM_BRAM; i++) w_bcs_sel[i] = (r_dest == 8'(i));
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_data = w_word_ins;
    w_push_be   = '1;
    if (r_state == S_DATA && w_acc && !w_fall && r_to_sdr && w_lane_last) begin
      w_push = 1'b1;
    end else if (r_state == S_PAD && !w_fall && !w_full) begin
      w_push      = 1'b1;
      w_push_data = r_word;
      w_push_be   = w_pad_be;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wp] <= r_wptr;
      r_fd[r_wp] <= w_push_data;
      r_fb[r_wp] <= w_push_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_req <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + c_pw'(1);
      if (w_pop)  r_rp <= r_rp + c_pw'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (c_pw+1)'(1);
        2'b01:   r_cnt <= r_cnt - (c_pw+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      // One idle cycle after each accept before the next request.
      r_req <= r_req ? ~sdr_rdy : (r_cnt != '0);
    end
  end

  assign sdr_req  = r_req & ~reset;
  assign sdr_addr = r_req ? r_fa[r_rp] : '0;
  assign sdr_data = r_req ? r_fd[r_rp] : '0;
  assign sdr_be   = r_req ? r_fb[r_rp] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dl_q <= 1'b0; r_wait_q <= 1'b0; r_err <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
      r_to_sdr <= 1'b0; r_hcnt <= '0; r_dest <= '0; r_len <= '0;
      r_lane <= '0; r_word <= '0; r_wptr <= c_base;
      r_bofs <= '0; r_baddr <= '0; r_bdata <= '0; r_bcs <= '0; r_bwr <= 1'b0;
    end else begin
      r_dl_q   <= ioctl_download;
      r_wait_q <= ioctl_wait;
      r_bwr    <= 1'b0;
      if (w_drop) r_err <= 1'b1;
      if (w_push) begin
        r_wptr <= r_wptr + ADDR_W'(c_bytes);
        r_lane <= '0;
        r_word <= '0;
      end
      case (r_state)
        S_IDLE, S_DONE, S_DONE_ERR: begin
          if (w_rise) begin
            r_state <= S_HDR;
            r_busy <= 1'b1; r_done <= 1'b0; r_err <= 1'b0;
            r_hcnt <= '0; r_lane <= '0; r_word <= '0; r_wptr <= c_base; r_bcs <= '0;
          end
        end
        S_HDR: begin
          if (w_fall) begin
            r_err <= 1'b1; r_bcs <= '0; r_state <= S_DRAIN;
          end else if (w_acc) begin
            if (r_hcnt == 2'd0) r_dest <= ioctl_data;
            else                r_len  <= w_len_full;
            r_hcnt <= r_hcnt + 2'd1;
            if (r_hcnt == 2'd3) begin
              if (w_len_full == 24'd0) begin
                r_bcs <= '0; r_state <= S_DRAIN;
              end else if (r_dest == 8'h80) begin
                r_to_sdr <= 1'b1; r_bcs <= '0; r_state <= S_DATA;
              end else if (int'(r_dest) < NUM_BRAM) begin
                r_to_sdr <= 1'b0; r_bcs <= w_bcs_sel; r_bofs <= '0; r_state <= S_DATA;
              end else begin
                r_err <= 1'b1; r_busy <= 1'b0; r_done <= 1'b0; r_bcs <= '0;
                r_state <= S_DONE_ERR;
              end
            end
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_err <= 1'b1; r_bcs <= '0; r_state <= S_DRAIN;
          end else if (w_acc) begin
            r_len <= r_len - 24'd1;
            if (r_to_sdr) begin
              if (!w_lane_last) begin
                r_word <= w_word_ins;
                r_lane <= r_lane + c_lw'(1);
              end
            end else begin
              r_bdata <= ioctl_data;
              r_baddr <= r_bofs;
              r_bwr   <= 1'b1;
              r_bofs  <= r_bofs + 20'd1;
            end
            if (r_len == 24'd1) r_state <= (r_to_sdr && !w_lane_last) ? S_PAD : S_HDR;
          end
        end
        S_PAD: begin
          if (w_fall) begin
            r_err <= 1'b1; r_state <= S_DRAIN;
          end else begin
            // The host may already have sent the next dest byte in this cycle.
            if (w_acc) begin
              r_dest <= ioctl_data;
              r_hcnt <= 2'd1;
            end
            if (!w_full) r_state <= S_HDR;
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0 && !r_req) begin
            r_busy  <= 1'b0;
            r_done  <= ~(r_err | w_drop);
            r_state <= (r_err | w_drop) ? S_DONE_ERR : S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_err;
  assign bram_addr = r_baddr;
  assign bram_data = r_bdata;
  assign bram_cs   = r_bcs;
  assign bram_wr   = r_bwr;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
    end else if ((r_state == S_IDLE || r_state == S_DONE || r_state == S_DONE_ERR) && w_rise) begin
      r_sum <= '0;
    end else if (r_state == S_DATA && w_acc && !w_fall) begin
      r_sum <= r_sum + {8'd0, ioctl_data};
    end
  end
  assign checksum = r_sum;
`else
  assign checksum = 16'd0;
`endif

endmodule
`default_nettype wire
